// File: rtl/bw_div_pkg.sv
// Shared types and constants for the bw_div sequential signed divider.
package bw_div_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bw_div_step.sv
// One restoring-division iteration on magnitudes (purely combinational).
module bw_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           bit_in,
  input  logic [WIDTH:0] dvs,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH:0] trial;

  assign trial   = (rem_in << 1) | {{WIDTH{1'b0}}, bit_in};
  assign q_bit   = (trial >= dvs);
  assign rem_out = q_bit ? (trial - dvs) : trial;

endmodule

// File: rtl/bw_div.sv
// Sequential signed divider: restoring steps on magnitudes, then sign fix-up.
// Optional: BW_DIV_ZERO_BYPASS_EN sends a zero divisor straight to DONE.
module bw_div
  import bw_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             ovf_p_q, ovf_p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_o_q, rem_o_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_ext, dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_ext = {divisor[WIDTH-1], divisor};
  assign dvs_mag = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;

  bw_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dq_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovf_p_d = ovf_p_q;
    quo_d   = quo_q;
    rem_o_d = rem_o_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          dq_d    = dvd_mag;
          dvs_d   = dvs_mag;
          rem_d   = '0;
          qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d  = dividend[WIDTH-1];
          ovf_p_d = (dividend == MIN_VAL) && (divisor == '1);
`ifdef BW_DIV_ZERO_BYPASS_EN
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_o_d = dividend;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end
`endif
        end
      end
      CALC: begin
        dq_d  = {dq_q[WIDTH-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves |dividend| in rem, so the normal remainder path yields the dividend.
        state_d = DONE;
        dz_d    = (dvs_q == '0);
        ovf_d   = ovf_p_q;
        quo_d   = (dvs_q == '0) ? '1 : (qneg_q ? -dq_q : dq_q);
        rem_o_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_p_q <= 1'b0;
      quo_q   <= '0;
      rem_o_q <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovf_p_q <= ovf_p_d;
      quo_q   <= quo_d;
      rem_o_q <= rem_o_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = rst_n && (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_o_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_bw_div.sv
// Randomized self-checking bench for bw_div against an integer-arithmetic model.
module tb_bw_div;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bw_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      q  = W'(-(1 << (W-1)));
      r  = '0;
      ov = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit early, input bit noise);
    logic [W-1:0] eq, er;
    logic         edz, eov;
    int           lat, exp_lat, t;
    ref_div(a, b, eq, er, edz, eov);
    exp_lat = W + 2;
`ifdef BW_DIV_ZERO_BYPASS_EN
    if (b == '0) exp_lat = 1;
`endif
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = early;
    step();
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    check("overflow", overflow, eov);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        step();
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        check("hold_quotient", quotient, eq);
        check("hold_remainder", remainder, er);
        check("hold_flags", {div_by_zero, overflow}, {edz, eov});
      end
      out_ready = 1'b1;
    end
    step();
    out_ready = 1'b0;
    check("valid_after_accept", out_valid, 0);
    check("flags_after_accept", {div_by_zero, overflow}, 2'b00);
    check("in_ready_after", in_ready, 1);
  endtask

  int corners [10] = '{0, 1, -1, 2, -2, 7, -7, 127, -128, -127};
  bit seen;

  initial begin
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_by_zero, overflow}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_release_in_ready", in_ready, 1);

    do_div(W'(100), W'(7), 0, 1'b0, 1'b0);
    do_div(W'(-100), W'(7), 0, 1'b0, 1'b0);
    do_div(W'(100), W'(-7), 0, 1'b0, 1'b0);
    do_div(W'(-128), W'(-1), 0, 1'b0, 1'b0);
    do_div(W'(-128), W'(1), 0, 1'b0, 1'b0);
    do_div(W'(5), W'(0), 0, 1'b0, 1'b0);
    do_div(W'(100), W'(7), 6, 1'b0, 1'b1);
    do_div(W'(-100), W'(-7), 0, 1'b1, 1'b0);
    do_div(W'(-77), W'(0), 0, 1'b1, 1'b0);

    // Abort mid-CALC: outputs still hold the previous result until reset hits.
    do_div(W'(100), W'(7), 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    dividend = W'(-99);
    divisor  = W'(5);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_flags", {div_by_zero, overflow}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("abort_release_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("abort_no_result", seen, 0);

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        do_div(W'(corners[i]), W'(corners[j]), 0, 1'b0, 1'b0);
      end
    end

    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 15) == 0) rb = '0;
      do_div(ra, rb, ($urandom_range(0, 7) == 0) ? 2 : 0,
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
